// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state enum and default geometry for the single-port SRAM arbiter
package sram_arb_pkg;

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

  localparam int BITS_DEF       = 8;
  localparam int WORD_DEPTH_DEF = 128;
  localparam int ADD_WIDTH_DEF  = 7;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with its priority register
module rr_arb2 (
  input  logic       CLK,
  input  logic       RSTB,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic prio_q, prio_d;

  // prio names the requester that wins a tie; it then moves to the loser.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = prio_q ? 2'b10 : 2'b01;
    end
    prio_d = prio_q;
    if (grant[0]) begin
      prio_d = 1'b1;
    end else if (grant[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/sram_1p_arbiter.sv
// rtl/sram_1p_arbiter.sv - zeroes a single-port SRAM, then arbitrates two requesters onto it
module sram_1p_arbiter
  import sram_arb_pkg::*;
#(
  parameter int Bits       = BITS_DEF,
  parameter int Word_Depth = WORD_DEPTH_DEF,
  parameter int Add_Width  = ADD_WIDTH_DEF
) (
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 clr,
  output logic                 init_done,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wen,
  input  logic [Add_Width-1:0] req0_addr,
  input  logic [Bits-1:0]      req0_wdata,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wen,
  input  logic [Add_Width-1:0] req1_addr,
  input  logic [Bits-1:0]      req1_wdata,
  output logic                 resp0_valid,
  output logic [Bits-1:0]      resp0_rdata,
  output logic                 resp1_valid,
  output logic [Bits-1:0]      resp1_rdata,
  output logic                 sram_CEB,
  output logic                 sram_WEB,
  output logic [Add_Width-1:0] sram_A,
  output logic [Bits-1:0]      sram_D,
  input  logic [Bits-1:0]      sram_Q
);

  localparam logic [Add_Width:0] ZC_LAST = (Add_Width+1)'(Word_Depth - 1);
  localparam logic [Add_Width:0] ZC_ONE  = {{Add_Width{1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [Add_Width:0] zero_cnt_q, zero_cnt_d;
  logic [1:0]         arb_valid, grant;
  logic [1:0]         rd_pend_q, rd_pend_d;

  assign arb_valid = (state_q == RUN) ? {req1_valid, req0_valid} : 2'b00;

  rr_arb2 u_arb (
    .CLK   (CLK),
    .RSTB  (RSTB),
    .valid (arb_valid),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign init_done  = (state_q == RUN);

  // Q is only meaningful the cycle after a read, so the data path is gated by the pending bit.
  assign rd_pend_d   = grant & ~{req1_wen, req0_wen};
  assign resp0_valid = rd_pend_q[0];
  assign resp1_valid = rd_pend_q[1];
  assign resp0_rdata = rd_pend_q[0] ? sram_Q : '0;
  assign resp1_rdata = rd_pend_q[1] ? sram_Q : '0;

  always_comb begin
    state_d    = state_q;
    zero_cnt_d = zero_cnt_q;
    sram_CEB   = 1'b1;
    sram_WEB   = 1'b1;
    sram_A     = '0;
    sram_D     = '0;
    // Reset also idles the macro pins combinationally, since INIT would otherwise enable it.
    if (RSTB) begin
      case (state_q)
        INIT: begin
          sram_CEB   = 1'b0;
          sram_WEB   = 1'b0;
          sram_A     = zero_cnt_q[Add_Width-1:0];
          zero_cnt_d = zero_cnt_q + ZC_ONE;
          if (zero_cnt_q == ZC_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (grant[1]) begin
            sram_CEB = 1'b0;
            sram_WEB = ~req1_wen;
            sram_A   = req1_addr;
            sram_D   = req1_wdata;
          end else if (grant[0]) begin
            sram_CEB = 1'b0;
            sram_WEB = ~req0_wen;
            sram_A   = req0_addr;
            sram_D   = req0_wdata;
          end
        end
        default: state_d = INIT;
      endcase
      if (clr) begin
        state_d    = INIT;
        zero_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      state_q    <= INIT;
      zero_cnt_q <= '0;
      rd_pend_q  <= '0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      rd_pend_q  <= rd_pend_d;
    end
  end

endmodule

// File: doc/sram_1p_arbiter.md
SRAM_1P_ARBITER -- requirements
Module: sram_1p_arbiter

Interface
REQ-001 Parameter Bits, default 8, data width of the SRAM macro.
REQ-002 Parameter Word_Depth, default 128, number of SRAM words.
REQ-003 Parameter Add_Width, default 7, address width; SHALL satisfy 2^Add_Width >= Word_Depth.
REQ-004 The block SHALL use one clock, CLK, and an asynchronous active-low reset, RSTB.
REQ-005 CLK  input  1  rising-edge clock for all state.
REQ-006 RSTB  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  one-cycle pulse that re-runs memory zeroing.
REQ-008 init_done  output  1  high when zeroing is complete and requests are accepted.
REQ-009 reqN_valid / reqN_ready  input / output  1 / 1  handshake for requester N (N = 0, 1).
REQ-010 reqN_wen  input  1  1 = write, 0 = read.
REQ-011 reqN_addr / reqN_wdata  input  Add_Width / Bits  access address and write data.
REQ-012 respN_valid / respN_rdata  output  1 / Bits  read response for requester N.
REQ-013 sram_CEB, sram_WEB  output  1  active-low chip enable and write enable to the macro.
REQ-014 sram_A / sram_D / sram_Q  output / output / input  Add_Width / Bits / Bits  macro address, write data and read data.

Function
REQ-015 States SHALL be INIT and RUN; a reset release SHALL enter INIT with zero_cnt = 0.
REQ-016 In INIT, each cycle SHALL drive sram_CEB=0, sram_WEB=0, sram_A=zero_cnt, sram_D=0, and increment zero_cnt.
REQ-017 After the write to address Word_Depth-1, the state SHALL change to RUN and init_done SHALL go high on the next cycle.
REQ-018 In INIT, both reqN_ready outputs SHALL be 0 and init_done SHALL be 0.
REQ-019 In RUN, at most one access SHALL be issued per cycle; a handshake fires when reqN_valid and reqN_ready are both high.
REQ-020 reqN_ready SHALL be a combinational grant, derived from the valids and the priority bit in the same cycle.
REQ-021 Arbitration: if only one valid is high, that requester SHALL be granted; if both are high, the requester selected by prio SHALL be granted.
REQ-022 After any grant, prio SHALL point to the non-granted requester; prio SHALL not change in cycles without a grant.
REQ-023 The issue cycle SHALL drive sram_CEB=0, sram_WEB=~wen, sram_A=addr and sram_D=wdata from the granted requester; with no grant, sram_CEB SHALL be 1.
REQ-024 Read latency: respN_valid SHALL be high exactly one cycle after the read handshake, with respN_rdata = sram_Q.
REQ-025 respN_rdata SHALL be 0 whenever respN_valid is 0, because macro Q is undefined after non-read cycles.
REQ-026 Writes SHALL produce no response.
REQ-027 A read to the address written in the previous cycle SHALL return the new data, with no forwarding logic needed.
REQ-028 A clr pulse in RUN SHALL take effect on the next edge: state INIT, zero_cnt = 0, init_done = 0.
REQ-029 A handshake in the same cycle as clr SHALL still complete, including its read response.
REQ-030 clr during INIT SHALL restart zero_cnt at 0.
REQ-031 zero_cnt SHALL be Add_Width+1 bits wide so that Word_Depth = 2^Add_Width terminates without wrap-around.

Reset
REQ-032 While RSTB = 0, the outputs SHALL be: sram_CEB=1, sram_WEB=1, sram_A=0, sram_D=0, reqN_ready=0, respN_valid=0, respN_rdata=0, init_done=0.
REQ-033 Reset SHALL set state=INIT, zero_cnt=0 and prio=0 (requester 0 first).
REQ-034 Reset assertion mid-INIT or mid-RUN SHALL abort immediately; a pending read response SHALL be discarded, and zeroing SHALL restart from address 0 after release.

Structure
REQ-035 A shared package sram_arb_pkg SHALL hold the state enum {INIT, RUN} and the default width and depth constants.
REQ-036 The two-way round-robin grant and prio register SHALL be a sub-module, rr_arb2 (inputs: valid[1:0]; outputs: grant[1:0] one-hot).
REQ-037 The implementation SHALL target 150-250 lines of RTL.

Verification
REQ-038 Reset release -> sram_CEB low for exactly 128 cycles with A = 0..127 and D = 0, then init_done=1; a read of addr 5 returns 0x00.
REQ-039 req0 writes 0x12 <- 0xA5, then reads 0x12 in the next cycle -> resp0_valid one cycle after the read handshake with rdata 0xA5; resp1_valid stays 0.
REQ-040 Both requesters hold read valid for 6 cycles -> grants 0,1,0,1,0,1, and each response returns on its own port one cycle after issue.
REQ-041 clr pulsed during a req1 read of addr 3 -> the read response still arrives; then 128 zeroing cycles run, with ready=0 throughout.
REQ-042 RSTB asserted when zero_cnt = 60 -> sram_CEB=1 immediately; after release, zeroing restarts at address 0.
REQ-043 Idle cycles with random sram_Q -> resp0_rdata = resp1_rdata = 0.
